// File: rtl/deser_rev.sv
// rtl/deser_rev.sv - serial-to-parallel receiver with selectable LSB/MSB-first bit order
module deser_rev #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         sin_first,
    input  logic         rev,
    output logic [N-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         ovf,
    input  logic         ovf_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          rev_l;

    logic          start;
    logic          shift_bit;
    logic          wr_en;
    logic          wr_rev;
    logic [CW-1:0] wr_k;
    logic [CW-1:0] wr_idx;
    logic          ovf_set;
    logic          last_bit;

    // Decode which bit (if any) lands in q this cycle and whether a bit is lost.
    always_comb begin
        start     = sin_valid && sin_first &&
                    (state == IDLE || state == SHIFT || (state == HOLD && q_ready));
        shift_bit = (state == SHIFT) && sin_valid && !sin_first;
        wr_en     = start || shift_bit;
        wr_rev    = start ? rev : rev_l;
        wr_k      = start ? '0 : count;
        wr_idx    = wr_rev ? (CW'(N - 1) - wr_k) : wr_k;
        last_bit  = shift_bit && (count == CW'(N - 1));
        ovf_set   = ((state == SHIFT) && sin_valid && sin_first) ||
                    ((state == HOLD) && !q_ready && sin_valid);
    end

    // Receive FSM: bit placement, word handoff and sticky overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            count   <= '0;
            rev_l   <= 1'b0;
            q       <= '0;
            q_valid <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            // Only the addressed bit of q is written; untouched bits keep old data.
            for (int i = 0; i < N; i++) begin
                if (wr_en && (wr_idx == CW'(i))) begin
                    q[i] <= sin;
                end
            end

            // Set takes priority over a simultaneous clear.
            ovf <= ovf_set || (ovf && !ovf_clr);

            case (state)
                IDLE: begin
                    if (start) begin
                        rev_l <= rev;
                        count <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        // Resynchronise on a new frame marker mid-word.
                        rev_l <= rev;
                        count <= CW'(1);
                    end else if (last_bit) begin
                        count   <= '0;
                        q_valid <= 1'b1;
                        state   <= HOLD;
                    end else if (shift_bit) begin
                        count <= count + CW'(1);
                    end
                end
                HOLD: begin
                    if (q_ready) begin
                        q_valid <= 1'b0;
                        if (start) begin
                            rev_l <= rev;
                            count <= CW'(1);
                            state <= SHIFT;
                        end else begin
                            count <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    count   <= '0;
                    q_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deser_rev.sv
// tb/tb_deser_rev.sv - self-checking bench for deser_rev
module tb_deser_rev;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin_first = 1'b0;
    logic         rev = 1'b0;
    logic         q_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [N-1:0] q;
    logic         q_valid;
    logic         ovf;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: collected bits of the word in flight and the delivered word.
    bit           m_busy = 0;
    bit           m_hold = 0;
    bit           m_rev = 0;
    bit           m_ovf = 0;
    logic [N-1:0] m_word = '0;
    bit           m_bits[$];

    always #5 clk = ~clk;

    deser_rev #(.N(N)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sin      (sin),
        .sin_valid(sin_valid),
        .sin_first(sin_first),
        .rev      (rev),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_hold = 0;
        m_rev  = 0;
        m_ovf  = 0;
        m_word = '0;
        m_bits.delete();
    endtask

    task automatic model_begin_word();
        m_bits.delete();
        m_bits.push_back(sin);
        m_rev  = rev;
        m_busy = 1;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit set;
        set = 0;
        if (!rstn) begin
            model_reset();
        end else begin
            if (m_hold) begin
                if (q_ready) begin
                    m_hold = 0;
                    if (sin_valid && sin_first) model_begin_word();
                end else if (sin_valid) begin
                    set = 1;
                end
            end else if (sin_valid) begin
                if (sin_first) begin
                    if (m_busy) set = 1;
                    model_begin_word();
                end else if (m_busy) begin
                    m_bits.push_back(sin);
                    if (m_bits.size() == N) begin
                        m_word = '0;
                        for (int k = 0; k < N; k++) begin
                            if (m_rev) m_word[N-1-k] = m_bits[k];
                            else       m_word[k]     = m_bits[k];
                        end
                        m_hold = 1;
                        m_busy = 0;
                    end
                end
            end
            m_ovf = set || (m_ovf && !ovf_clr);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic f, input logic r,
                        input logic rd, input logic c);
        sin       = s;
        sin_valid = v;
        sin_first = f;
        rev       = r;
        q_ready   = rd;
        ovf_clr   = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic rd);
        step(1'b0, 1'b0, 1'b0, 1'b0, rd, 1'b0);
    endtask

    // Stream bit k of st is the k-th serial bit; tog flips rev from bit 4 on.
    task automatic send_word(input logic [N-1:0] st, input logic r, input logic tog, input logic rd);
        for (int k = 0; k < N; k++) begin
            step(st[k], 1'b1, (k == 0), (tog && k >= 4) ? ~r : r, rd, 1'b0);
        end
    endtask

    task automatic reset_now(input string tag);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk({tag, "_q"}, q, 0);
        chk({tag, "_q_valid"}, q_valid, 0);
        chk({tag, "_ovf"}, ovf, 0);
        idle(1'b0);
        rstn = 1'b1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_q_valid", q_valid, m_hold);
        chk("cyc_ovf", ovf, m_ovf);
        if (m_hold) chk("cyc_q", q, m_word);
    end

    initial begin
        model_reset();
        idle(1'b0);
        idle(1'b0);
        chk("rst_q", q, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_ovf", ovf, 0);
        rstn = 1'b1;
        idle(1'b0);

        // LSB-first word, one-cycle valid pulse.
        send_word(8'h8D, 1'b0, 1'b0, 1'b1);
        chk("lsb_q", q, 8'h8D);
        chk("lsb_q_valid", q_valid, 1);
        chk("lsb_ovf", ovf, 0);
        idle(1'b1);
        chk("lsb_pulse_end", q_valid, 0);

        // MSB-first, then with rev toggled mid-word.
        send_word(8'h8D, 1'b1, 1'b0, 1'b1);
        chk("msb_q", q, 8'hB1);
        idle(1'b1);
        send_word(8'h8D, 1'b1, 1'b1, 1'b1);
        chk("msb_tog_q", q, 8'hB1);
        idle(1'b1);

        // Held word with dropped bits, then clear.
        send_word(8'h8D, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, (i < 3), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_q", q, 8'h8D);
        chk("hold_q_valid", q_valid, 1);
        chk("hold_ovf", ovf, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_ovf", ovf, 0);
        chk("clr_q_valid", q_valid, 0);

        // Back-to-back words with first bit in the handshake cycle.
        send_word(8'h8D, 1'b0, 1'b0, 1'b1);
        chk("b2b_q0", q, 8'h8D);
        send_word(8'h8D, 1'b1, 1'b0, 1'b1);
        chk("b2b_q1", q, 8'hB1);
        chk("b2b_q_valid", q_valid, 1);
        chk("b2b_ovf", ovf, 0);
        idle(1'b1);

        // Resync after three bits.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, (i == 0), 1'b0, 1'b1, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("resync_ovf", ovf, 1);
        chk("resync_q", q, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("resync_clr", ovf, 0);

        // Asynchronous reset mid-SHIFT (count=4).
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 1'b0, 1'b1, 1'b0);
        reset_now("rst_shift");
        send_word(8'h8D, 1'b0, 1'b0, 1'b1);
        chk("post_shift_rst_q", q, 8'h8D);
        idle(1'b1);

        // Asynchronous reset mid-HOLD.
        send_word(8'hA5, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        reset_now("rst_hold");
        send_word(8'h0F, 1'b1, 1'b0, 1'b1);
        chk("post_hold_rst_q", q, 8'hF0);
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/deser_rev.md
Name: deser_rev

Overview:
- Serial-to-parallel receiver and bit-order restorer. It is the receiving end of the bit-reordering combinational mapper used on the parallel side.
- It takes a 1-bit stream with a frame-start marker and assembles N-bit words, in LSB-first or MSB-first order as selected.
- It presents each word to a downstream consumer over a valid/ready handshake.
- Bit placement is done with an indexed for loop inside the clocked process. This exercises the for-in-sequential-always case for triplication.

Parameters:
- N, 8, word width in bits; legal range N >= 2.
- CW, $clog2(N), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous reset, active-low.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is valid this cycle. No backpressure toward the serial side.
- sin_first  input  1  qualifies sin_valid; marks bit 0 of a word.
- rev  input  1  order select: 0 = LSB-first stream, 1 = MSB-first stream. Sampled with bit 0 of each word.
- q  output  N  assembled word.
- q_valid  output  1  q holds a complete word.
- q_ready  input  1  consumer accepts q.
- ovf  output  1  sticky overflow flag: a bit was dropped.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (rstn low, asynchronous): q=0, q_valid=0, ovf=0, state=IDLE, count=0, rev_l=0. Release is synchronous to clk.
- States: IDLE, SHIFT, HOLD. An accepted bit is one with sin_valid=1 in IDLE or SHIFT.
- IDLE:
  - sin_valid & sin_first: store the bit as bit 0, latch rev_l=rev, count=1, go to SHIFT.
  - sin_valid & !sin_first: bit discarded, ovf unchanged; this is alignment hunting.
- SHIFT:
  - Accepted bit k (k = count) goes to q[k] if rev_l=0, or to q[N-1-k] if rev_l=1. Other bits of q hold.
  - count increments per accepted bit.
  - On bit N-1: q_valid=1 from the next cycle, go to HOLD. Latency from last bit to q_valid is 1 cycle.
  - sin_valid & sin_first in SHIFT: resynchronise. Discard the partial word, set ovf=1, take this bit as bit 0, relatch rev, count=1.
- HOLD:
  - q and q_valid stable until q_ready=1.
  - q_ready=1 with no sin_valid: q_valid=0 next cycle, go to IDLE. q retains its value.
  - q_ready=1 with sin_valid & sin_first in the same cycle: handshake completes and the bit is accepted as bit 0 of the next word. Go to SHIFT with count=1. This gives zero-bubble back-to-back words.
  - q_ready=1 with sin_valid & !sin_first in the same cycle: handshake completes, bit discarded, go to IDLE.
  - q_ready=0 with sin_valid=1: bit dropped, ovf=1.
- Word build: bits of q not yet written in the current word hold their previous values. Only q_valid qualifies q.
- ovf:
  - Set by a drop in HOLD or by a resync in SHIFT.
  - ovf_clr=1 clears it next cycle. If a set and ovf_clr occur in the same cycle, set wins.
- Counter wrap: count never reaches N. It returns to 0 or 1 on entering IDLE or SHIFT respectively.
- rev changes mid-word are ignored; only rev_l is used.

Test Plan:
- N=8, rev=0, bits 1,0,1,1,0,0,0,1 (first on bit 1), q_ready=1 -> q=0x8D, q_valid for exactly 1 cycle, 1 cycle after the 8th bit; ovf=0.
- Same stream with rev=1 -> q=0xB1. Toggle rev mid-word -> q still 0xB1.
- q_ready=0 for 5 cycles after a word, 3 sin_valid bits during HOLD -> q stable at 0x8D, ovf=1. ovf_clr pulse -> ovf=0 next cycle.
- Two words back-to-back (0x8D then 0xB1, rev=0/1), q_ready=1, next first bit arriving in the handshake cycle -> both words delivered, no dropped bit, ovf=0.
- sin_first reasserted after 3 bits of a word -> ovf=1, and the following 8 bits assemble the correct new word.
- Assert rstn low mid-SHIFT (count=4) and mid-HOLD -> q=0, q_valid=0, ovf=0 immediately (asynchronous). The first word after release decodes correctly.
